// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch and
// DMEM-wait hazards into per-stage enables, with a DMEM timeout FSM and perf counters.
module pipeline_stall_ctrl #(
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_nstall_i,
    input  logic             branch_taken_i,
    input  logic             ex_mem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             if_id_write_o,
    output logic             if_id_flush_o,
    output logic             id_ex_write_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_write_o,
    output logic             mem_wb_bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        DEC_NORMAL  = 2'd0,
        DEC_LOADUSE = 2'd1,
        DEC_BRANCH  = 2'd2,
        DEC_FREEZE  = 2'd3
    } dec_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_bubble;
    } ctrl_t;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic  freeze_c;
    dec_e  dec_c;
    ctrl_t ctrl_c;

    // Hazard priority: a pending memory access freezes everything, a taken branch
    // squashes whatever a load-use stall would have held.
    assign freeze_c = ex_mem_req_i && !dmem_ready_i;

    always_comb begin
        dec_c = DEC_NORMAL;
        if (freeze_c) begin
            dec_c = DEC_FREEZE;
        end else if (branch_taken_i) begin
            dec_c = DEC_BRANCH;
        end else if (!data_nstall_i) begin
            dec_c = DEC_LOADUSE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state: DMEM wait tracking and timeout
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            ST_RUN: begin
                if (freeze_c) begin
                    state_d    = ST_DWAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_DWAIT: begin
                if (!freeze_c) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
                    state_d   = ST_ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Output decode; reset overrides everything with a full-pipeline bubble
    always_comb begin
        ctrl_c = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                   id_ex_write: 1'b1, id_ex_flush: 1'b0, ex_mem_write: 1'b1,
                   mem_wb_bubble: 1'b0};
        if (rst) begin
            ctrl_c = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                       id_ex_write: 1'b0, id_ex_flush: 1'b1, ex_mem_write: 1'b0,
                       mem_wb_bubble: 1'b1};
        end else if (state_q == ST_ERR) begin
            ctrl_c = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                       id_ex_write: 1'b0, id_ex_flush: 1'b0, ex_mem_write: 1'b0,
                       mem_wb_bubble: 1'b1};
        end else begin
            unique case (dec_c)
                DEC_FREEZE: begin
                    ctrl_c.pc_write      = 1'b0;
                    ctrl_c.if_id_write   = 1'b0;
                    ctrl_c.id_ex_write   = 1'b0;
                    ctrl_c.ex_mem_write  = 1'b0;
                    ctrl_c.mem_wb_bubble = 1'b1;
                end
                DEC_BRANCH: begin
                    ctrl_c.if_id_flush = 1'b1;
                    ctrl_c.id_ex_flush = 1'b1;
                end
                DEC_LOADUSE: begin
                    ctrl_c.pc_write    = 1'b0;
                    ctrl_c.if_id_write = 1'b0;
                    ctrl_c.id_ex_flush = 1'b1;
                end
                default: begin
                    ctrl_c.pc_write = 1'b1;
                end
            endcase
        end
    end

    // Saturating performance counters, frozen once the pipeline has errored out
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != ST_ERR) begin
            if (!ctrl_c.pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if ((dec_c == DEC_BRANCH) && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign pc_write_o      = ctrl_c.pc_write;
    assign if_id_write_o   = ctrl_c.if_id_write;
    assign if_id_flush_o   = ctrl_c.if_id_flush;
    assign id_ex_write_o   = ctrl_c.id_ex_write;
    assign id_ex_flush_o   = ctrl_c.id_ex_flush;
    assign ex_mem_write_o  = ctrl_c.ex_mem_write;
    assign mem_wb_bubble_o = ctrl_c.mem_wb_bubble;
    assign mem_err_o       = mem_err_q;
    assign stall_cnt_o     = stall_cnt_q;
    assign flush_cnt_o     = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl (16-bit and 4-bit counter instances).
module tb_pipeline_stall_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_bubble}
    localparam logic [6:0] V_NORM = 7'b1101010;
    localparam logic [6:0] V_LU   = 7'b0001110;
    localparam logic [6:0] V_BR   = 7'b1111110;
    localparam logic [6:0] V_FRZ  = 7'b0000001;
    localparam logic [6:0] V_ERR  = 7'b0000001;
    localparam logic [6:0] V_RST  = 7'b0010101;

    logic clk = 1'b0;
    logic rst, dn, br, req, rdy;

    logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b, err;
    logic [15:0] stall_cnt, flush_cnt;
    logic pc_w4, ifid_w4, ifid_f4, idex_w4, idex_f4, exmem_w4, memwb_b4, err4;
    logic [3:0] stall_cnt4, flush_cnt4;

    int n_chk  = 0;
    int n_fail = 0;

    pipeline_stall_ctrl #(.MAX_WAIT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .data_nstall_i(dn), .branch_taken_i(br),
        .ex_mem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(pc_w), .if_id_write_o(ifid_w), .if_id_flush_o(ifid_f),
        .id_ex_write_o(idex_w), .id_ex_flush_o(idex_f), .ex_mem_write_o(exmem_w),
        .mem_wb_bubble_o(memwb_b), .mem_err_o(err),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_stall_ctrl #(.MAX_WAIT(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .data_nstall_i(dn), .branch_taken_i(br),
        .ex_mem_req_i(req), .dmem_ready_i(rdy),
        .pc_write_o(pc_w4), .if_id_write_o(ifid_w4), .if_id_flush_o(ifid_f4),
        .id_ex_write_o(idex_w4), .id_ex_flush_o(idex_f4), .ex_mem_write_o(exmem_w4),
        .mem_wb_bubble_o(memwb_b4), .mem_err_o(err4),
        .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic d, input logic b, input logic q, input logic y);
        rst = r; dn = d; br = b; req = q; rdy = y;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Inputs settle, then the combinational enables are sampled mid-cycle
    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        #2;
        chk(tag, 32'({pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b}), 32'(exp));
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc();
        chk_ctrl("reset_outputs", V_RST);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("reset_mem_err", 32'(err), 32'd0);
        cyc();

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk_ctrl("idle_advance", V_NORM);
            cyc();
        end
        chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("idle_flush_cnt", 32'(flush_cnt), 32'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_ctrl("loaduse", V_LU);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("loaduse_stall_cnt", 32'(stall_cnt), 32'd1);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_ctrl("branch_over_loaduse", V_BR);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("branch_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("branch_stall_cnt", 32'(stall_cnt), 32'd1);

        // Freeze for 3 cycles with branch pending, release on ready
        do_reset();
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_ctrl("freeze_hold", V_FRZ);
            cyc();
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk_ctrl("ready_branch", V_BR);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ctrl("after_ready_run", V_NORM);
        chk("freeze_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("freeze_flush_cnt", 32'(flush_cnt), 32'd1);

        // Dropped request clears the wait count; then full timeout
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ctrl("req_drop_run", V_NORM);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            chk_ctrl("timeout_frozen", V_FRZ);
            chk("timeout_err_pending", 32'(err), 32'd0);
            cyc();
        end
        chk("timeout_mem_err", 32'(err), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_ctrl("err_halt_idle", V_ERR);
        chk("timeout_stall_cnt", 32'(stall_cnt), 32'd14);
        cyc();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk_ctrl("err_halt_ready", V_ERR);
        cyc();
        cyc();
        chk("err_stall_hold", 32'(stall_cnt), 32'd14);
        chk("err_flush_hold", 32'(flush_cnt), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("err_cleared", 32'(err), 32'd0);
        chk_ctrl("err_reset_run", V_NORM);

        // Counter saturation on the 4-bit instance
        do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_stall_cnt4", 32'(stall_cnt4), 32'd15);
        chk("nosat_stall_cnt16", 32'(stall_cnt), 32'd20);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_flush_cnt4", 32'(flush_cnt4), 32'd15);
        chk("nosat_flush_cnt16", 32'(flush_cnt), 32'd17);

        // Reset in the middle of a DMEM wait
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        chk("dwait_stall_cnt", 32'(stall_cnt), 32'd3);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_ctrl("rst_in_dwait", V_RST);
        cyc();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst_dwait_stall", 32'(stall_cnt), 32'd0);
        chk("rst_dwait_flush", 32'(flush_cnt), 32'd0);
        chk("rst_dwait_err", 32'(err), 32'd0);
        chk_ctrl("rst_dwait_run", V_NORM);
        cyc();

        // Fresh wait after reset must again take 9 frozen cycles to fail
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc();
        chk("post_rst_no_err", 32'(err), 32'd0);
        cyc();
        chk("post_rst_err", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Merges three hazard sources into per-stage write enables and flushes:
  - load-use stall request from the ID-stage hazard detector (data_nstall, active-low);
  - taken-branch redirect from EX;
  - data-memory wait handshake from MEM.
- Owns a DMEM wait FSM with timeout, a sticky error flag, and saturating stall/flush performance counters.

Parameters:
- MAX_WAIT, 8: maximum consecutive cycles the pipeline may be frozen waiting for dmem_ready before a timeout error. Legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- data_nstall  in  1  0 = load-use hazard between ID/EX load and IF/ID instruction
- branch_taken  in  1  EX-stage branch/jump resolved taken this cycle
- ex_mem_req  in  1  instruction in MEM stage performs a load/store
- dmem_ready  in  1  data memory completes the access this cycle
- pc_write  out  1  PC register load enable
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID load a NOP
- id_ex_write  out  1  ID/EX register load enable
- id_ex_flush  out  1  ID/EX load a bubble (control bits zeroed)
- ex_mem_write  out  1  EX/MEM register load enable
- mem_wb_bubble  out  1  MEM/WB load a bubble (RegWrite=0)
- mem_err  out  1  sticky DMEM timeout flag
- stall_cnt  out  CNT_W  cycles with pc_write=0, saturating
- flush_cnt  out  CNT_W  branch-flush cycles, saturating

Behaviour:

Reset (rst=1 at a clock edge):
- state←RUN, wait_cnt←0, mem_err←0, stall_cnt←0, flush_cnt←0.
- While rst is high the outputs are forced regardless of state:
  - pc_write=0, all *_write=0;
  - if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
- Reset mid-DWAIT or in ERR returns to RUN the next cycle.

States: RUN, DWAIT, ERR. Outputs are combinational from state and inputs. Defaults for every decode below: all *_write=1, all flush/bubble=0.

Decode in RUN and DWAIT, priority highest first:
1. Freeze (ex_mem_req=1 and dmem_ready=0):
   - pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_write=0, mem_wb_bubble=1.
   - No flushes. branch_taken and data_nstall are ignored; they persist because EX and ID are held.
2. Branch (branch_taken=1):
   - pc_write=1, if_id_flush=1, id_ex_flush=1.
   - A simultaneous load-use stall is ignored, since the stalled instruction is squashed.
3. Load-use (data_nstall=0):
   - pc_write=0, if_id_write=0, id_ex_flush=1. EX/MEM/WB advance.
4. Otherwise: normal advance.

ERR decode:
- All *_write=0, flushes=0, mem_wb_bubble=1.
- Pipeline is permanently halted until rst.

Transitions:
- RUN→DWAIT when Freeze holds; wait_cnt←1.
- DWAIT→RUN when dmem_ready=1.
  - That cycle decodes as non-freeze, so the pipeline advances in the same cycle ready is seen.
  - wait_cnt←0.
- DWAIT stays in DWAIT while Freeze holds and wait_cnt<MAX_WAIT; wait_cnt increments.
- DWAIT→ERR when Freeze holds and wait_cnt==MAX_WAIT; mem_err←1.
  - Total frozen cycles before error = MAX_WAIT+1: the entry cycle plus MAX_WAIT DWAIT cycles.
- DWAIT with ex_mem_req=0 (request dropped): →RUN, wait_cnt←0.
- ERR stays in ERR.

Counters:
- stall_cnt increments each non-reset cycle where pc_write=0 and state≠ERR.
- flush_cnt increments each cycle the Branch decode is selected.
- Both saturate at 2^CNT_W−1 (no wrap).
- Both hold in ERR.

Test Plan:
- Reset, then all inputs idle (data_nstall=1, others 0) for 5 cycles → all *_write=1, no flushes, stall_cnt=0, flush_cnt=0.
- data_nstall=0 for 1 cycle → that cycle pc_write=0, if_id_write=0, id_ex_flush=1, ex_mem_write=1; stall_cnt=1 afterwards.
- branch_taken=1 and data_nstall=0 in the same cycle → pc_write=1, if_id_flush=1, id_ex_flush=1; flush_cnt=1, stall_cnt unchanged.
- ex_mem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 with branch_taken=1 held throughout:
  - 3 frozen cycles (pc_write=0, mem_wb_bubble=1) with no flush;
  - 4th cycle: branch flush asserted, state=RUN;
  - stall_cnt=3, flush_cnt=1.
- MAX_WAIT=8, ex_mem_req=1 with dmem_ready held 0:
  - after 9 frozen cycles mem_err=1 and state=ERR, all enables 0;
  - later dmem_ready=1 keeps ERR;
  - rst pulse returns to RUN with mem_err=0.
- CNT_W=4, data_nstall=0 for 20 cycles → stall_cnt stops at 15.
- Assert rst during DWAIT → next cycle state=RUN, counters 0, all enables 1 once rst is released.
